eeprom_boot_loader: RTL
=======================

// Module: eeprom_boot_loader
// PURPOSE
//  Upstream programmer for the parallel EEPROM. At boot it accepts a byte stream and writes
//  each byte to consecutive addresses from 0. It times /WE pulses and the write cycle, then
//  reads each byte back to verify it. N_BOOTED deasserts only after the whole image verifies.
//  While the loader is not in DONE it owns the EEPROM bus; the system control path must hold its /WE high.
// PARAMETERS
//  DEPTH        17    address width in bits
//  WIDTH        8     data width in bits
//  COUNT        1<<17 bytes to program; range 1..(1<<DEPTH)
//  WE_PULSE     4     cycles /WE is held low per write, >=1
//  WRITE_CYCLES 500   cycles waited after /WE rises (tWC), >=1
//  READ_CYCLES  2     cycles /OE is low before the verify sample, >=1
// PORTS
//  CLK          in   1      clock, rising edge
//  N_RST        in   1      asynchronous active-low reset
//  START        in   1      1-cycle pulse; starts programming from IDLE
//  IN_DATA      in   WIDTH  stream byte
//  IN_VALID     in   1      IN_DATA valid
//  IN_READY     out  1      loader accepts IN_DATA this cycle
//  EE_ADDR      out  DEPTH  EEPROM address
//  EE_DATA_OUT  out  WIDTH  write data
//  EE_DATA_OE   out  1      1 = loader drives the EEPROM data bus
//  EE_DATA_IN   in   WIDTH  EEPROM read data
//  EE_N_WE      out  1      EEPROM write enable, active low
//  EE_N_OE      out  1      EEPROM output enable, active low
//  N_BOOTED     out  1      1 until programming verifies; 0 in DONE
//  BUSY         out  1      1 in any state except IDLE, DONE, ERROR
//  ERR          out  1      sticky verify-mismatch flag
// BEHAVIOUR
//  Reset: state=IDLE; EE_ADDR=0, EE_DATA_OUT=0, EE_DATA_OE=0, EE_N_WE=1, EE_N_OE=1,
//   IN_READY=0, N_BOOTED=1, BUSY=0, ERR=0. All outputs are registered.
//  IDLE: START=1 -> WAIT_DATA. Address counter=0.
//  WAIT_DATA: IN_READY=1. Handshake occurs when IN_VALID&IN_READY. The byte is latched into
//   EE_DATA_OUT and the state goes to SETUP. IN_READY is 0 in every other state.
//  SETUP (1 cycle): EE_DATA_OE=1, N_WE=1 (address/data setup) -> PULSE.
//  PULSE (WE_PULSE cycles): EE_N_WE=0 -> HOLD.
//  HOLD (1 cycle): EE_N_WE=1, data is still driven -> WAIT_WC with EE_DATA_OE=0.
//  WAIT_WC (WRITE_CYCLES cycles): bus idle -> VERIFY.
//  VERIFY (READ_CYCLES cycles): EE_N_OE=0, EE_DATA_OE=0. EE_DATA_IN is sampled in the last cycle.
//   On mismatch: ERR=1 -> ERROR. On match: if addr==COUNT-1 -> DONE, else addr+1 -> WAIT_DATA.
//  EE_N_OE=0 and EE_DATA_OE=1 never occur in the same cycle. At least one cycle separates them.
//  The address counter is DEPTH bits wide and never wraps: COUNT-1 is the final address.
//  Cycles per byte with a stalled-free stream: 1+1+WE_PULSE+1+WRITE_CYCLES+READ_CYCLES.
//  DONE: N_BOOTED=0, bus released (N_WE=1, N_OE=1, OE=0). Held until reset. START is ignored.
//  ERROR: N_BOOTED=1, ERR=1, bus released. Held until reset. START is ignored.
//  START while BUSY is ignored. IN_VALID outside WAIT_DATA is ignored and no byte is consumed.
//  Reset mid-write (any state): outputs return to reset values asynchronously, so /WE rises at once.
//   The EEPROM byte may be corrupt. Reprogramming restarts at address 0.
//  Phase timers are a single down-counter wide enough for max(WE_PULSE,WRITE_CYCLES,READ_CYCLES).
//   It is loaded on each state entry.
// STRUCTURE
//  Shared package (common.v): state enum typedef ee_ldr_state_t {IDLE,WAIT_DATA,SETUP,PULSE,
//   HOLD,WAIT_WC,VERIFY,DONE,ERROR}, and a clog2-based timer-width function.
//  One sub-module is natural: ee_phase_timer (load value, start, done pulse), reused per phase.
//  The rest is one FSM plus an address register.
// TESTING (bench: instantiate with the eeprom model extended with write support; COUNT=4,
//  WE_PULSE=2, WRITE_CYCLES=5, READ_CYCLES=2)
//  1. Reset, then stream A5,5A,FF,00 with IN_VALID held -> mem[0..3]=A5,5A,FF,00.
//     N_BOOTED falls 1 cycle after the 4th verify. ERR=0. Byte period = 12 cycles.
//  2. Per-write timing check -> N_WE low for exactly 2 cycles. ADDR/DATA stable from SETUP through HOLD.
//     Never OE=1 with N_OE=0.
//  3. IN_VALID gaps of 7 cycles between bytes -> loader waits in WAIT_DATA with the bus idle.
//     Result matches scenario 1.
//  4. Model corrupts the readback at addr 2 (returns 0x7F for FF) -> ERR=1, N_BOOTED stays 1.
//     No write to addr 3. START is then ignored.
//  5. Assert N_RST low during PULSE of addr 1 -> EE_N_WE=1 the same cycle, all outputs at reset values.
//     Restart rewrites addr 0 first.
//  6. START pulses while BUSY and IN_VALID outside WAIT_DATA -> no state change, no extra byte consumed.

Source files
------------

// File: rtl/eeprom_boot_loader_pkg.sv
// Shared types and helpers for the EEPROM boot loader: FSM state encoding
// and the sizing function for the shared phase timer.
package eeprom_boot_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    PULSE,
    HOLD,
    WAIT_WC,
    VERIFY,
    DONE,
    ERROR
  } ee_ldr_state_t;

  // Counter holds (phase length - 1), so clog2 of the longest phase is enough.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/eeprom_boot_loader_phase_timer.sv
// Down-counter shared by all timed phases; reloaded on every state entry and
// pulses done in the final cycle of the phase.
module eeprom_boot_loader_phase_timer
  import eeprom_boot_loader_pkg::*;
#(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [TW-1:0] load,
  output logic          done
);

  logic [TW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= load;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/eeprom_boot_loader.sv
// Boot-time EEPROM programmer: writes a byte stream to consecutive addresses,
// times /WE and tWC, reads each byte back and releases N_BOOTED once all verify.
module eeprom_boot_loader
  import eeprom_boot_loader_pkg::*;
#(
  parameter int DEPTH        = 17,
  parameter int WIDTH        = 8,
  parameter int COUNT        = 1 << 17,
  parameter int WE_PULSE     = 4,
  parameter int WRITE_CYCLES = 500,
  parameter int READ_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DEPTH-1:0] ee_addr,
  output logic [WIDTH-1:0] ee_data_out,
  output logic             ee_data_oe,
  input  logic [WIDTH-1:0] ee_data_in,
  output logic             ee_n_we,
  output logic             ee_n_oe,
  output logic             n_booted,
  output logic             busy,
  output logic             err
);

  localparam int             TW        = timer_width(WE_PULSE, WRITE_CYCLES, READ_CYCLES);
  localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(COUNT - 1);

  ee_ldr_state_t state, state_nxt;
  logic          tmr_start, tmr_done;
  logic [TW-1:0] tmr_load;
  logic          hs, verify_ok, last_addr;
  logic          in_ready_d, oe_d, n_we_d, n_oe_d, n_booted_d, busy_d, err_d;

  assign hs        = in_ready && in_valid;
  assign verify_ok = (ee_data_in == ee_data_out);
  assign last_addr = (ee_addr == LAST_ADDR);

  eeprom_boot_loader_phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .start (tmr_start),
    .load  (tmr_load),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = WAIT_DATA;
      WAIT_DATA: if (hs) state_nxt = SETUP;
      SETUP:     state_nxt = PULSE;
      PULSE:     if (tmr_done) state_nxt = HOLD;
      HOLD:      state_nxt = WAIT_WC;
      WAIT_WC:   if (tmr_done) state_nxt = VERIFY;
      VERIFY: begin
        if (tmr_done) begin
          if (!verify_ok)     state_nxt = ERROR;
          else if (last_addr) state_nxt = DONE;
          else                state_nxt = WAIT_DATA;
        end
      end
      default:   state_nxt = state;
    endcase
  end

  // Timer is reloaded on every state change; only timed phases use it.
  always_comb begin
    tmr_start = (state_nxt != state);
    tmr_load  = '0;
    case (state_nxt)
      PULSE:   tmr_load = TW'(WE_PULSE - 1);
      WAIT_WC: tmr_load = TW'(WRITE_CYCLES - 1);
      VERIFY:  tmr_load = TW'(READ_CYCLES - 1);
      default: tmr_load = '0;
    endcase
  end

  // Outputs decoded from the next state and registered, so they track the state exactly.
  always_comb begin
    in_ready_d = 1'b0;
    oe_d       = 1'b0;
    n_we_d     = 1'b1;
    n_oe_d     = 1'b1;
    n_booted_d = 1'b1;
    busy_d     = 1'b1;
    err_d      = 1'b0;
    case (state_nxt)
      IDLE:        busy_d = 1'b0;
      WAIT_DATA:   in_ready_d = 1'b1;
      SETUP, HOLD: oe_d = 1'b1;
      PULSE: begin
        oe_d   = 1'b1;
        n_we_d = 1'b0;
      end
      VERIFY:      n_oe_d = 1'b0;
      DONE: begin
        busy_d     = 1'b0;
        n_booted_d = 1'b0;
      end
      ERROR: begin
        busy_d = 1'b0;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_ready   <= 1'b0;
      ee_data_oe <= 1'b0;
      ee_n_we    <= 1'b1;
      ee_n_oe    <= 1'b1;
      n_booted   <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      in_ready   <= in_ready_d;
      ee_data_oe <= oe_d;
      ee_n_we    <= n_we_d;
      ee_n_oe    <= n_oe_d;
      n_booted   <= n_booted_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  // Address never wraps: it stops advancing once the final byte verifies.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ee_addr     <= '0;
      ee_data_out <= '0;
    end else begin
      if (state == IDLE)
        ee_addr <= '0;
      else if (state == VERIFY && tmr_done && verify_ok && !last_addr)
        ee_addr <= ee_addr + 1'b1;
      if (hs)
        ee_data_out <= in_data;
    end
  end

endmodule
